// File: rtl/fmap_pkg.sv
// Shared feature-map geometry helpers, address type and zero-fill state encoding
// used by the buffer and the engines that address it.
package fmap_pkg;

  localparam int FMAP_DATA_WIDTH = 16;
  localparam int FMAP_CHANNELS   = 8;
  localparam int FMAP_IMG_SIZE   = 28;

  function automatic int fmap_depth(input int channels, input int img_size);
    return channels * img_size * img_size;
  endfunction

  function automatic int fmap_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int FMAP_DEPTH = fmap_depth(FMAP_CHANNELS, FMAP_IMG_SIZE);
  localparam int FMAP_AW    = fmap_aw(FMAP_DEPTH);

  typedef logic [FMAP_AW-1:0] addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } fill_state_t;

endpackage

// File: rtl/fmap_fill_seq.sv
// Zero-fill sequencer: walks a pointer over every word and requests a zero write
// through the buffer's write-port override, then pulses done for one cycle.
module fmap_fill_seq
  import fmap_pkg::*;
#(
  parameter int DEPTH = FMAP_DEPTH,
  parameter int AW    = FMAP_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          fill_we,
  output logic [AW-1:0] fill_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  fill_state_t   state, state_next;
  logic [AW-1:0] ptr, ptr_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // clr_start only matters in IDLE, so a re-trigger mid-fill cannot restart it
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    clr_busy   = 1'b0;
    clr_done   = 1'b0;
    fill_we    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clr_start) begin
          state_next = ST_FILL;
          ptr_next   = '0;
        end
      end
      ST_FILL: begin
        clr_busy = 1'b1;
        fill_we  = 1'b1;
        if (ptr == LAST_ADDR) begin
          state_next = ST_DONE;
        end else begin
          ptr_next = ptr + AW'(1);
        end
      end
      ST_DONE: begin
        clr_done   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign fill_addr = ptr;

endmodule

// File: rtl/fmap_bram.sv
// In-place CHANNELS x IMG_SIZE x IMG_SIZE feature-map store: combinational read
// port A, registered write port B, zero-fill sequencer and sticky error flags.
module fmap_bram
  import fmap_pkg::*;
#(
  parameter  int DATA_WIDTH = FMAP_DATA_WIDTH,
  parameter  int CHANNELS   = FMAP_CHANNELS,
  parameter  int IMG_SIZE   = FMAP_IMG_SIZE,
  localparam int DEPTH      = fmap_depth(CHANNELS, IMG_SIZE),
  localparam int AW         = fmap_aw(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AW-1:0]         conv_r_addr,
  input  logic                  conv_r_en,
  output logic [DATA_WIDTH-1:0] conv_r_q,
  input  logic [AW-1:0]         conv_w_addr,
  input  logic                  conv_w_en,
  input  logic                  conv_w_we,
  input  logic [DATA_WIDTH-1:0] conv_w_d,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  input  logic                  err_clr,
  output logic                  err_oob,
  output logic                  err_wr_blocked
);

  // One spare bit so the range check works even when DEPTH is a power of two
  localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

  // Distributed RAM: a synchronous block RAM could not give a same-cycle read
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          r_in_range;
  logic          w_in_range;
  logic          wr_strobe;
  logic          user_we;
  logic          fill_we;
  logic [AW-1:0] fill_addr;
  logic          oob_set;
  logic          blk_set;

  fmap_fill_seq #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fill_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_start(clr_start),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .fill_we  (fill_we),
    .fill_addr(fill_addr)
  );

  assign r_in_range = ({1'b0, conv_r_addr} < DEPTH_LIM);
  assign w_in_range = ({1'b0, conv_w_addr} < DEPTH_LIM);
  assign wr_strobe  = conv_w_en && conv_w_we;
  assign user_we    = wr_strobe && !clr_busy && w_in_range;

  assign conv_r_q = r_in_range ? mem[conv_r_addr] : '0;

  // Reset gates the write so an aborted fill leaves the pending word untouched
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_we) begin
        mem[fill_addr] <= '0;
      end else if (user_we) begin
        mem[conv_w_addr] <= conv_w_d;
      end
    end
  end

  assign oob_set = (conv_r_en && !r_in_range) || (wr_strobe && !w_in_range);
  assign blk_set = wr_strobe && clr_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_oob        <= 1'b0;
      err_wr_blocked <= 1'b0;
    end else begin
      err_oob        <= oob_set || (err_oob && !err_clr);
      err_wr_blocked <= blk_set || (err_wr_blocked && !err_clr);
    end
  end

endmodule
